// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter fed by one-cycle write strobes.
// The serializer drains the FIFO and chains frames without idle bits while data is queued.
module uart_tx_buffered #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_busy,
    output logic                     o_uart_tx
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = $clog2(CPB);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_state_n;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count, w_count_n;
    logic            r_full, r_empty, r_overflow;
    logic [BW-1:0]   r_baud, w_baud_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_tx, w_tx_n;
    logic            w_push, w_pop, w_bit_end;

    // Push is gated by the registered full flag, so a same-cycle pop never rescues it.
    assign w_push    = i_wr_en && !r_full;
    assign w_bit_end = r_baud == BAUD_LAST;
    assign w_count_n = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_push);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_count    <= w_count_n;
            r_full     <= w_count_n == FULL_CNT;
            r_empty    <= w_count_n == '0;
            r_overflow <= r_overflow | (i_wr_en & r_full);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = w_bit_end ? '0 : r_baud + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_n = '0;
                w_tx_n   = 1'b1;
                if (!r_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = r_mem[r_rd_ptr];
                    w_state_n = START;
                    w_tx_n    = 1'b0;
                end
            end
            START: if (w_bit_end) begin
                w_state_n = DATA;
                w_bit_n   = '0;
                w_tx_n    = r_shift[0];
            end
            DATA: if (w_bit_end) begin
                w_shift_n = r_shift >> 1;
                w_state_n = (r_bit == 3'd7) ? STOP : DATA;
                w_bit_n   = r_bit + 3'd1;
                w_tx_n    = (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            end
            STOP: if (w_bit_end) begin
                // Chain straight into the next start bit when data is waiting.
                w_pop     = !r_empty;
                w_shift_n = r_empty ? r_shift : r_mem[r_rd_ptr];
                w_state_n = r_empty ? IDLE : START;
                w_tx_n    = r_empty;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_busy     = r_state != IDLE;
    assign o_uart_tx  = r_tx;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for the buffered UART transmitter (CPB=4, DEPTH=4).
module tb_uart_tx_buffered;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, uart_tx;
    logic [2:0] count;
    int         errs = 0;
    int         checks = 0;

    uart_tx_buffered #(.CLK_HZ(40), .BAUD(10), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
        .o_busy(busy), .o_uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a start bit, then captures 40 negedge samples of one frame.
    task automatic recv_frame(output logic [7:0] d, output logic good, output int wait_n);
        logic [39:0] s;
        bit hit;
        d = '0; good = 1'b0; wait_n = 0; hit = 1'b0; s = '1;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            wait_n++;
            if (uart_tx === 1'b0) hit = 1'b1;
        end
        if (!hit) begin
            wait_n = -1;
            return;
        end
        s[0] = 1'b0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            s[i] = uart_tx;
        end
        good = (s[3:0] === 4'b0000) && (s[39:36] === 4'b1111);
        for (int b = 0; b < 8; b++) begin
            d[b] = s[4 + 4 * b + 1];
            good = good && (s[4 + 4 * b +: 4] === {4{s[4 + 4 * b]}});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL rst_hold_tx: got %b want 1", uart_tx); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic g;
        int w;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL single_tx_pre: got %b want 1", uart_tx); end
        checks++; if (count !== 3'd1) begin errs++; $display("FAIL single_count_pre: got %0d want 1", count); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_pre: got %b want 0", busy); end
        fork
            recv_frame(d, g, w);
            begin
                @(negedge clk);
                checks++; if (empty !== 1'b1) begin errs++; $display("FAIL single_empty_pop: got %b want 1", empty); end
                checks++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy_start: got %b want 1", busy); end
            end
        join
        checks++; if (w !== 1) begin errs++; $display("FAIL single_latency: got %0d want 1", w); end
        checks++; if (d !== 8'hA5) begin errs++; $display("FAIL single_data: got %h want a5", d); end
        checks++; if (g !== 1'b1) begin errs++; $display("FAIL single_framing: got %b want 1", g); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy_stop: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        checks++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL single_idle_tx: got %b want 1", uart_tx); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d [3];
        logic g [3];
        int w [3];
        logic [2:0] exp_cnt [3];
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
        fork
            for (int i = 0; i < 3; i++) recv_frame(d[i], g[i], w[i]);
            begin
                for (int i = 0; i < 3; i++) begin
                    wr_en = 1'b1; wr_data = 8'(i + 1);
                    @(negedge clk);
                    checks++; if (count !== exp_cnt[i]) begin errs++; $display("FAIL b2b_count%0d: got %0d want %0d", i, count, exp_cnt[i]); end
                end
                wr_en = 1'b0;
            end
        join
        for (int i = 0; i < 3; i++) begin
            checks++; if (d[i] !== 8'(i + 1) || g[i] !== 1'b1) begin errs++; $display("FAIL b2b_frame%0d: got %h/%b want %h/1", i, d[i], g[i], 8'(i + 1)); end
            checks++; if (w[i] !== (i == 0 ? 2 : 1)) begin errs++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, w[i], (i == 0 ? 2 : 1)); end
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin errs++; $display("FAIL b2b_drained: got empty=%b count=%0d want 1/0", empty, count); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [7:0] d [5];
        logic g [5];
        int w [5];
        int lows;
        fork
            for (int i = 0; i < 5; i++) recv_frame(d[i], g[i], w[i]);
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
                    @(negedge clk);
                    if (i == 4) begin
                        checks++; if (count !== 3'd4 || full !== 1'b1) begin errs++; $display("FAIL ovf_fill: got count=%0d full=%b want 4/1", count, full); end
                        checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_early: got %b want 0", overflow); end
                    end
                end
                wr_en = 1'b0;
                checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errs++; $display("FAIL ovf_drop: got ovf=%b count=%0d want 1/4", overflow, count); end
            end
        join
        for (int i = 0; i < 5; i++) begin
            checks++; if (d[i] !== 8'h10 + 8'(i) || g[i] !== 1'b1) begin errs++; $display("FAIL ovf_frame%0d: got %h/%b want %h/1", i, d[i], g[i], 8'h10 + 8'(i)); end
        end
        checks++; if (w[4] !== 1) begin errs++; $display("FAIL ovf_gap: got %0d want 1", w[4]); end
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errs++; $display("FAIL ovf_no_extra: got %0d low samples want 0", lows); end
        checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid;
        int lows;
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL rmid_queued: got %0d want 2", count); end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL rmid_abort: got tx=%b busy=%b want 1/0", uart_tx, busy); end
        checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin errs++; $display("FAIL rmid_clear: got count=%0d empty=%b ovf=%b want 0/1/0", count, empty, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (80) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++; if (lows !== 0) begin errs++; $display("FAIL rmid_silent: got %0d active samples want 0", lows); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL rmid_count: got %0d want 0", count); end
    endtask

    task automatic test_push_at_stop;
        logic [7:0] d [3];
        logic g [3];
        int w [3];
        fork
            for (int i = 0; i < 3; i++) recv_frame(d[i], g[i], w[i]);
            begin
                wr_en = 1'b1; wr_data = 8'h3C;
                @(negedge clk);
                wr_data = 8'hC3;
                @(negedge clk);
                wr_en = 1'b0;
                repeat (39) @(negedge clk);
                checks++; if (count !== 3'd1 || uart_tx !== 1'b1) begin errs++; $display("FAIL stop_pre: got count=%0d tx=%b want 1/1", count, uart_tx); end
                wr_en = 1'b1; wr_data = 8'h5A;
                @(negedge clk);
                wr_en = 1'b0;
                checks++; if (count !== 3'd1) begin errs++; $display("FAIL stop_count: got %0d want 1", count); end
                checks++; if (uart_tx !== 1'b0) begin errs++; $display("FAIL stop_next_start: got %b want 0", uart_tx); end
            end
        join
        checks++; if (d[0] !== 8'h3C || d[1] !== 8'hC3 || d[2] !== 8'h5A) begin errs++; $display("FAIL stop_order: got %h %h %h want 3c c3 5a", d[0], d[1], d[2]); end
        checks++; if (!(g[0] && g[1] && g[2])) begin errs++; $display("FAIL stop_framing: got %b%b%b want 111", g[0], g[1], g[2]); end
        checks++; if (w[1] !== 1 || w[2] !== 1) begin errs++; $display("FAIL stop_gap: got %0d %0d want 1 1", w[1], w[2]); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        test_push_at_stop;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
